// File: rtl/wb_mem_slave_pkg.sv
// rtl/wb_mem_slave_pkg.sv - shared constants for the wishbone boot memory slave
package wb_mem_slave_pkg;

  localparam logic [2:0] CTI_CLASSIC      = 3'b000;
  localparam logic [2:0] CTI_INC_BURST    = 3'b010;
  localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_WAIT = 3'd1;
  localparam logic [2:0] ST_WR_ACK  = 3'd2;
  localparam logic [2:0] ST_RD_LAT  = 3'd3;
  localparam logic [2:0] ST_RD_BEAT = 3'd4;

  // Address hits the array when every bit above the word-index field matches the base.
  function automatic logic addr_in_range(input logic [31:0] adr, input logic [31:0] base,
                                         input int unsigned aw);
    return ((adr ^ base) >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/wb_mem_slave_ram.sv
// rtl/wb_mem_slave_ram.sv - single-port synchronous 32-bit RAM with byte write enables
module wb_mem_slave_ram #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  input  logic                  we,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - on-chip RAM slave: wishbone write cycles, streamed read bursts
module wb_mem_slave
  import wb_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic        wb_read_i,
  input  logic [2:0]  wb_burstcount_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_readdatavalid_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        proto_err_o
);

  localparam logic [1:0] WAIT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;
  localparam logic [1:0] LAT_INIT  = 2'(READ_LATENCY - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  oor;
  logic [1:0]            wait_cnt;
  logic [1:0]            lat_cnt;
  logic [2:0]            beats_left;
  logic                  proto_err;
  logic [31:0]           ram_q;
  logic                  wr_start;
  logic                  wr_beat;
  logic                  in_range;
  logic                  rd_state;
  logic                  unused_bte;

  assign wr_start = wb_cyc_i & wb_stb_i & wb_we_i;
  assign wr_beat  = (state == ST_WR_ACK) & wb_cyc_i & wb_stb_i;
  assign in_range = addr_in_range(wb_adr_i, BASE_ADDR, ADDR_WIDTH);
  assign rd_state = (state == ST_RD_LAT) | (state == ST_RD_BEAT);
  assign unused_bte = (wb_bte_i != BTE_LINEAR);

  // RAM output lags its address by a cycle, so during beats fetch the next word ahead.
  assign ram_addr = (state == ST_RD_BEAT) ? beat_addr + ADDR_WIDTH'(1) : beat_addr;

  wb_mem_slave_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .wdata (wb_dat_i),
    .be    (wb_sel_i),
    .we    (wr_beat & ~oor),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      beat_addr  <= '0;
      oor        <= 1'b0;
      wait_cnt   <= 2'd0;
      lat_cnt    <= 2'd0;
      beats_left <= 3'd0;
      proto_err  <= 1'b0;
    end else begin
      if ((wb_read_i && state != ST_IDLE) || (wb_stb_i && wb_we_i && rd_state) ||
          (wr_beat && wb_sel_i == 4'b0000)) begin
        proto_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (wr_start) begin
            beat_addr <= wb_adr_i[ADDR_WIDTH+1:2];
            oor       <= ~in_range;
            wait_cnt  <= WAIT_INIT;
            state     <= (WAIT_STATES == 0) ? ST_WR_ACK : ST_WR_WAIT;
          end else if (wb_read_i) begin
            beat_addr  <= wb_adr_i[ADDR_WIDTH+1:2];
            oor        <= ~in_range;
            beats_left <= (wb_burstcount_i == 3'd0) ? 3'd1 : wb_burstcount_i;
            lat_cnt    <= LAT_INIT;
            state      <= ST_RD_LAT;
          end
        end
        ST_WR_WAIT: begin
          if (!wb_cyc_i) state <= ST_IDLE;
          else if (wait_cnt == 2'd0) state <= ST_WR_ACK;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        ST_WR_ACK: begin
          if (!wb_cyc_i) begin
            state <= ST_IDLE;
          end else if (wb_stb_i) begin
            beat_addr <= beat_addr + ADDR_WIDTH'(1);
            if (wb_cti_i != CTI_INC_BURST) state <= ST_IDLE;
          end
        end
        ST_RD_LAT: begin
          if (lat_cnt == 2'd0) state <= ST_RD_BEAT;
          else lat_cnt <= lat_cnt - 2'd1;
        end
        ST_RD_BEAT: begin
          beat_addr <= beat_addr + ADDR_WIDTH'(1);
          if (beats_left <= 3'd1) state <= ST_IDLE;
          else beats_left <= beats_left - 3'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wb_ack_o           = wr_beat & ~oor;
  assign wb_err_o           = wr_beat & oor;
  assign wb_readdatavalid_o = (state == ST_RD_BEAT);
  assign wb_dat_o           = (state == ST_RD_BEAT && !oor) ? ram_q : 32'h0;
  assign wb_rty_o           = 1'b0;
  assign proto_err_o        = proto_err;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - randomized self-checking bench for wb_mem_slave
module tb_wb_mem_slave;
  import wb_mem_slave_pkg::*;

  localparam int AW = 12;
  localparam int WS = 1;
  localparam int RL = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int WORDS = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic        wb_read_i = 1'b0;
  logic [2:0]  wb_burstcount_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_readdatavalid_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic        proto_err_o;

  always #5 clk = ~clk;

  wb_mem_slave #(
    .ADDR_WIDTH   (AW),
    .BASE_ADDR    (BASE),
    .WAIT_STATES  (WS),
    .READ_LATENCY (RL)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wb_adr_i           (wb_adr_i),
    .wb_dat_i           (wb_dat_i),
    .wb_sel_i           (wb_sel_i),
    .wb_we_i            (wb_we_i),
    .wb_cyc_i           (wb_cyc_i),
    .wb_stb_i           (wb_stb_i),
    .wb_cti_i           (wb_cti_i),
    .wb_bte_i           (wb_bte_i),
    .wb_read_i          (wb_read_i),
    .wb_burstcount_i    (wb_burstcount_i),
    .wb_dat_o           (wb_dat_o),
    .wb_ack_o           (wb_ack_o),
    .wb_readdatavalid_o (wb_readdatavalid_o),
    .wb_err_o           (wb_err_o),
    .wb_rty_o           (wb_rty_o),
    .proto_err_o        (proto_err_o)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] model [int];
  logic [31:0] wdata [4];
  logic [3:0]  wsel [4];
  logic [31:0] rd_seen [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit in_range(input logic [31:0] adr);
    return (adr / 32'(WORDS * 4)) == (BASE / 32'(WORDS * 4));
  endfunction

  function automatic int word_of(input logic [31:0] adr, input int i);
    return int'(((adr >> 2) + 32'(i)) % 32'(WORDS));
  endfunction

  // Words never fully written stay unknown and are not compared.
  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    if (!model.exists(w)) begin
      if (s == 4'hF) model[w] = d;
      return;
    end
    v = model[w];
    for (int k = 0; k < 4; k++) if (s[k]) v[8*k +: 8] = d[8*k +: 8];
    model[w] = v;
  endtask

  task automatic do_write(input logic [31:0] adr, input int n, input bit with_read);
    int c;
    bit ok;
    ok = in_range(adr);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_read_i = with_read;
    for (int b = 0; b < n; b++) begin
      wb_dat_i = wdata[b];
      wb_sel_i = wsel[b];
      wb_cti_i = (n == 1) ? CTI_CLASSIC : (b == n - 1) ? CTI_END_OF_BURST : CTI_INC_BURST;
      c = 0;
      if (b == 0) begin
        @(posedge clk); #1;
        wb_read_i = 1'b0;
        c = 1;
      end
      forever begin
        @(negedge clk);
        if (wb_ack_o || wb_err_o || c >= 20) break;
        c++;
      end
      check("wr_latency", 32'(c), (b == 0) ? 32'(1 + WS) : 32'd0);
      check("wr_ack", 32'(wb_ack_o), 32'(ok));
      check("wr_err", 32'(wb_err_o), 32'(!ok));
      if (ok) model_write(word_of(adr, b), wdata[b], wsel[b]);
      @(posedge clk); #1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = CTI_CLASSIC; wb_sel_i = '0;
    @(negedge clk);
    check("wr_idle_ackerr", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] adr, input int bc, input bit poke);
    int n;
    int c;
    int w;
    bit ok;
    n = (bc == 0) ? 1 : bc;
    ok = in_range(adr);
    @(posedge clk); #1;
    wb_read_i = 1'b1; wb_adr_i = adr; wb_burstcount_i = 3'(bc);
    @(negedge clk);
    check("rd_cmd_no_ack", 32'(wb_ack_o), 32'd0);
    @(posedge clk); #1;
    wb_read_i = 1'b0;
    c = 1;
    forever begin
      @(negedge clk);
      if (wb_readdatavalid_o || c >= 20) break;
      c++;
    end
    check("rd_latency", 32'(c), 32'(1 + RL));
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      rd_seen[i] = wb_dat_o;
      check("rd_valid", 32'(wb_readdatavalid_o), 32'd1);
      w = word_of(adr, i);
      if (!ok) check("rd_oor_zero", wb_dat_o, 32'h0);
      else if (model.exists(w)) check("rd_data", wb_dat_o, model[w]);
      if (poke && i == 0) wb_read_i = 1'b1;
      if (poke && i == 1) wb_read_i = 1'b0;
    end
    @(negedge clk);
    check("rd_done", 32'(wb_readdatavalid_o), 32'd0);
  endtask

  initial begin
    int c;
    int extra;
    logic [31:0] adr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_err", 32'(wb_err_o), 32'd0);
    check("rst_rdv", 32'(wb_readdatavalid_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_rty", 32'(wb_rty_o), 32'd0);
    check("rst_proto", 32'(proto_err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // classic write, then a partial-byte update
    wdata[0] = 32'hDEAD_BEEF; wsel[0] = 4'hF;
    do_write(32'h10, 1, 1'b0);
    wdata[0] = 32'hA5A5_1234; wsel[0] = 4'b0110;
    do_write(32'h10, 1, 1'b0);
    do_read(32'h10, 1, 1'b0);
    check("partial_bytes", rd_seen[0], 32'hDEA5_12EF);

    // incrementing burst
    wdata = '{32'h11, 32'h22, 32'h33, 32'h44};
    wsel  = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'h20, 4, 1'b0);
    do_read(32'h20, 4, 1'b0);
    check("burst_beat3", rd_seen[3], 32'h44);

    // wrap at top of array
    wdata = '{32'hCAFE_0FFF, 32'hCAFE_0000, 32'hCAFE_0001, 32'h0};
    do_write(32'h3FFC, 3, 1'b0);
    do_read(32'h3FFC, 3, 1'b0);
    check("wrap_beat1", rd_seen[1], 32'hCAFE_0000);

    // out of range
    wdata[0] = 32'hBAD0_BAD0; wsel[0] = 4'hF;
    do_write(BASE + 32'h4000, 1, 1'b0);
    do_read(32'h0, 1, 1'b0);
    check("oor_no_alias", rd_seen[0], 32'hCAFE_0000);
    do_read(BASE + 32'h4000, 2, 1'b0);

    // protocol violations
    check("proto_before", 32'(proto_err_o), 32'd0);
    do_read(32'h20, 4, 1'b1);
    check("proto_rd_in_beat", 32'(proto_err_o), 32'd1);
    wdata[0] = 32'h5555_AAAA; wsel[0] = 4'hF;
    do_write(32'h30, 1, 1'b1);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      extra += int'(wb_readdatavalid_o);
    end
    check("ignored_read", 32'(extra), 32'd0);
    check("proto_sticky", 32'(proto_err_o), 32'd1);
    do_read(32'h30, 1, 1'b0);

    // reset in the middle of a read burst
    @(posedge clk); #1;
    wb_read_i = 1'b1; wb_adr_i = 32'h20; wb_burstcount_i = 3'd4;
    @(posedge clk); #1;
    wb_read_i = 1'b0;
    c = 1;
    forever begin
      @(negedge clk);
      if (wb_readdatavalid_o || c >= 20) break;
      c++;
    end
    check("rstmid_latency", 32'(c), 32'(1 + RL));
    @(negedge clk);
    check("rstmid_beat2", wb_dat_o, 32'h22);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_rdv", 32'(wb_readdatavalid_o), 32'd0);
    check("rstmid_dat", wb_dat_o, 32'h0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      extra += int'(wb_readdatavalid_o);
    end
    check("rstmid_no_beats", 32'(extra), 32'd0);
    check("rstmid_proto", 32'(proto_err_o), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    do_read(32'h20, 1, 1'b0);

    // zero byte enables: acked, nothing written, flagged
    wdata[0] = 32'hFFFF_FFFF; wsel[0] = 4'h0;
    do_write(32'h20, 1, 1'b0);
    check("proto_sel0", 32'(proto_err_o), 32'd1);
    do_read(32'h20, 1, 1'b0);

    // random traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      int n;
      if ($urandom_range(0, 1) == 1) adr = 32'($urandom_range(WORDS - 6, WORDS - 1)) * 4;
      else adr = 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 7) == 0) adr = adr + 32'(WORDS * 4) * 32'($urandom_range(1, 3));
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 4; b++) begin
          wdata[b] = $urandom;
          wsel[b]  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
        end
        do_write(adr, n, 1'b0);
      end else begin
        do_read(adr, $urandom_range(0, 4), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- On-chip RAM Wishbone slave sitting directly downstream of the CPU memory bus master; it serves that master's write cycles and read bursts.
- Write protocol: Wishbone classic and incrementing-burst write cycles (cyc/stb/we/cti/sel).
- Read protocol: a one-cycle read command followed by streamed readdatavalid beats.
- Used as the simulation and FPGA boot memory behind the master.

Parameters:
- ADDR_WIDTH, 12: log2 of the word count of the internal array (default 4096 x 32 bit).
- BASE_ADDR, 32'h0000_0000: byte base address. Bits above ADDR_WIDTH+1 must match, otherwise the access is out of range.
- WAIT_STATES, 1: idle cycles between a write stb/command and the first ack (0..3).
- READ_LATENCY, 2: cycles from read command capture to the first readdatavalid beat (1..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_adr_i  in  32  byte address; held constant by the master for a whole burst
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  000 classic, 010 incrementing burst, 111 end of burst
- wb_bte_i  in  2  only linear (00) is supported; other values are treated as 00
- wb_read_i  in  1  read command request
- wb_burstcount_i  in  3  read beats, 1..4; 0 is treated as 1
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  write beat acknowledge
- wb_readdatavalid_o  out  1  read beat valid
- wb_err_o  out  1  out-of-range write acknowledge (replaces ack)
- wb_rty_o  out  1  tied 0
- proto_err_o  out  1  sticky protocol violation flag

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs 0, state IDLE, counters 0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst; pending beats are dropped.
- FSM states: IDLE, WR_WAIT, WR_ACK, RD_LAT, RD_BEAT.
- IDLE:
  - cyc&stb&we: latch beat_addr = wb_adr_i[ADDR_WIDTH+1:2] and the range check result. Go to WR_WAIT, or to WR_ACK if WAIT_STATES=0.
  - Otherwise wb_read_i: latch beat_addr, beats = burstcount, lat = READ_LATENCY-1. Go to RD_LAT.
  - wb_ack_o stays 0 during read command capture; the master drops wb_read_i on seeing no ack.
  - cyc&stb&we together with wb_read_i: the write wins and the read is ignored.
- WR_WAIT: count WAIT_STATES cycles, then go to WR_ACK.
- WR_ACK:
  - With stb high, assert ack (or err) for exactly one cycle per beat.
  - On ack (not err), write wb_dat_i bytes per sel into the array at beat_addr.
  - After each beat, beat_addr increments by 1 and wraps modulo 2^ADDR_WIDTH.
  - cti=010 with cyc still high: the next beat is acked back to back, with no wait states after the first beat.
  - cti=000 or 111, or cyc low: return to IDLE, and ack is low the following cycle.
  - cyc falling without a final ack: return to IDLE immediately, with no array write.
- RD_LAT: count down lat; at 0 go to RD_BEAT.
- RD_BEAT:
  - One readdatavalid beat per cycle, with wb_dat_o = array[beat_addr]; beat_addr increments each beat.
  - Out-of-range beats return 32'h0 with readdatavalid still asserted.
  - After the last beat (beats reaches 0), return to IDLE.
- Synchronous array read: the address is presented one cycle ahead, so READ_LATENCY>=1 is mandatory.
- proto_err_o is set, sticky until reset, by:
  - wb_read_i high outside IDLE;
  - stb&we high in a read state;
  - a wb_sel_i=0 write beat. This beat is still acked, with no bytes written.
- Write-then-read to the same address in consecutive cycles returns the new data.

Decomposition:
- Shared package/defines: CTI codes (CLASSIC, INC_BURST, END_OF_BURST), BTE_LINEAR, FSM state encodings.
- One sub-module: wb_mem_slave_ram, a single-port synchronous RAM with byte-write enables (ADDR_WIDTH, 32-bit, 4 sel).
  - Kept separate so FPGA builds can swap in vendor RAM.

Test Plan:
- Classic write (WAIT_STATES=1), adr 0x10, data 0xA5A5_1234, sel 0110, cyc held until ack:
  - ack appears exactly 2 cycles after stb;
  - a following read of 1 beat at 0x10 returns 0x??A5_12?? with only bytes 1-2 changed from prior contents.
- Incrementing write burst, cti=010, adr 0x20, 4 beats 0x11/0x22/0x33/0x44:
  - first ack after wait states, then 3 back-to-back acks;
  - a 4-beat read at 0x20 returns 0x11,0x22,0x33,0x44 on consecutive readdatavalid cycles starting READ_LATENCY cycles after command.
- Read burstcount=3 at 0x3FFC with ADDR_WIDTH=12:
  - beats wrap to word 0 and word 1;
  - exactly 3 readdatavalid pulses, then IDLE.
- Out-of-range write at BASE_ADDR+0x4000:
  - wb_err_o pulses instead of ack;
  - array unchanged, so a read of word 0 still returns its old value;
  - out-of-range read returns 0 with readdatavalid.
- wb_read_i asserted during RD_BEAT and again with cyc&stb&we simultaneously:
  - proto_err_o goes 1 and stays 1;
  - the write is serviced and the extra read is ignored.
- rst_n low in the middle of a 4-beat read after beat 2:
  - outputs 0 immediately, with no further readdatavalid;
  - after release, a new 1-beat read completes normally.
